// File: rtl/bsg_mem_adapter_pkg.sv
// Shared types for the 1rw synchronous memory request adapter.
package bsg_mem_adapter_pkg;

    typedef enum logic {
        eInit,
        eRun
    } state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO; also accepts an enqueue while full when the
// head is dequeued in the same cycle.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign v_o     = (r_count != 2'd0);
    assign ready_o = (r_count != 2'd2);
    assign w_deq   = yumi_i & v_o;
    assign w_enq   = v_i & (ready_o | w_deq);
    assign data_o  = r_mem[r_rptr];

    // NOTE: non-blocking assignments on all state so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // NOTE: storage is deliberately not reset; r_count decides which
    // entries are meaningful, so the array can map onto plain flops/RAM.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_req_adapter.sv
// Ready/valid front end for a 1rw synchronous memory: optional clear sweep,
// credit-gated request acceptance and a two-entry read response buffer.
module bsg_mem_1rw_sync_req_adapter
    import bsg_mem_adapter_pkg::*;
#(
    parameter int width_p          = -1,
    parameter int els_p            = -1,
    parameter int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int clear_on_reset_p = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic [width_p-1:0]       mem_data_i,
    output logic                     init_done_o
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   r_state;
    logic [addr_width_lp-1:0] r_sweep;
    logic                     r_inflight;
    logic [1:0]               r_buf_count;

    logic       w_run;
    logic       w_init;
    logic       w_deq;
    logic       w_accept;
    logic [2:0] w_used;
    logic       w_fifo_v;
    logic       w_fifo_ready;

    assign w_run  = (r_state == eRun) & ~reset_i;
    assign w_init = (r_state == eInit) & ~reset_i;

    // Credits cover buffered entries plus the read whose data lands next
    // cycle; a same-cycle dequeue frees one. Independent of w_i on purpose.
    assign w_used   = {1'b0, r_buf_count} + {2'b0, r_inflight};
    assign ready_o  = w_run & ((w_used - {2'b0, w_deq}) < 3'd2);
    assign w_accept = v_i & ready_o;

    assign v_o         = w_fifo_v & ~reset_i;
    assign w_deq       = yumi_i & v_o;
    assign init_done_o = w_run;

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (w_init) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = r_sweep;
        end else if (w_run) begin
            mem_v_o    = w_accept;
            mem_w_o    = w_i;
            mem_addr_o = addr_i;
            mem_data_o = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= (clear_on_reset_p != 0) ? eInit : eRun;
            r_sweep     <= '0;
            r_inflight  <= 1'b0;
            r_buf_count <= 2'd0;
        end else begin
            r_inflight  <= w_accept & ~w_i;
            r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_deq};
            case (r_state)
                eInit: begin
                    if (r_sweep == last_addr_lp) r_state <= eRun;
                    else                         r_sweep <= r_sweep + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read data is only valid the cycle after the command, so it is
    // captured exactly then.
    bsg_two_fifo #(
        .width_p (width_p)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (w_fifo_ready),
        .data_i  (mem_data_i),
        .v_i     (r_inflight),
        .v_o     (w_fifo_v),
        .data_o  (data_o),
        .yumi_i  (w_deq)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        assert (els_p >= 1) else $error("els_p must be at least 1");
        if (!reset_i) begin
            assert (!(yumi_i && !v_o)) else $error("yumi_i asserted without v_o");
            assert (!(v_i && $isunknown(w_i))) else $error("w_i unknown while v_i");
            assert (!(r_inflight && !w_fifo_ready && !w_deq))
                else $error("response buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_req_adapter.sv
// Directed scoreboard bench: stimulus pushes expected read responses, a
// monitor pops and compares them as the DUT hands responses out.
module tb_bsg_mem_1rw_sync_req_adapter;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         exact;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       v_i;
    logic       w_i;
    logic [2:0] addr_i;
    logic [7:0] data_i;
    logic       yumi_en;
    logic       yumi_i;
    logic       ready_o;
    logic       v_o;
    logic [7:0] data_o;
    logic       mem_v_o;
    logic       mem_w_o;
    logic [2:0] mem_addr_o;
    logic [7:0] mem_data_o;
    logic [7:0] mem_data_i;
    logic       init_done_o;

    logic       nc_ready_o;
    logic       nc_v_o;
    logic [7:0] nc_data_o;
    logic       nc_mem_v_o;
    logic       nc_mem_w_o;
    logic [2:0] nc_mem_addr_o;
    logic [7:0] nc_mem_data_o;
    logic       nc_init_done_o;

    logic [7:0] tb_mem [8];
    exp_t       q [$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign yumi_i = yumi_en & v_o;

    bsg_mem_1rw_sync_req_adapter #(
        .width_p          (8),
        .els_p            (8),
        .clear_on_reset_p (1)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .w_i         (w_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .mem_v_o     (mem_v_o),
        .mem_w_o     (mem_w_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .init_done_o (init_done_o)
    );

    bsg_mem_1rw_sync_req_adapter #(
        .width_p          (8),
        .els_p            (8),
        .clear_on_reset_p (0)
    ) dut_nc (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (1'b0),
        .w_i         (1'b0),
        .addr_i      (3'd0),
        .data_i      (8'd0),
        .ready_o     (nc_ready_o),
        .v_o         (nc_v_o),
        .data_o      (nc_data_o),
        .yumi_i      (1'b0),
        .mem_v_o     (nc_mem_v_o),
        .mem_w_o     (nc_mem_w_o),
        .mem_addr_o  (nc_mem_addr_o),
        .mem_data_o  (nc_mem_data_o),
        .mem_data_i  (8'd0),
        .init_done_o (nc_init_done_o)
    );

    // Synchronous-read SRAM model; read data is garbage on any cycle
    // not directly following a read command.
    always @(posedge clk) begin
        if (mem_v_o && mem_w_o) tb_mem[mem_addr_o] <= mem_data_o;
        if (mem_v_o && !mem_w_o) mem_data_i <= tb_mem[mem_addr_o];
        else                     mem_data_i <= 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_i && v_o && yumi_i) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 32'(v_o), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_data", 32'(data_o), 32'(e.data));
                if (e.exact) check("resp_latency", 32'(cyc), 32'(e.due));
                else         check("resp_min_latency", 32'(cyc >= e.due), 32'd1);
            end
        end
    end

    task automatic req(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic exp_ready, input logic push,
                       input logic [7:0] exp_d, input bit exact);
        v_i    = 1'b1;
        w_i    = w;
        addr_i = a;
        data_i = d;
        @(negedge clk);
        check("req_ready", 32'(ready_o), 32'(exp_ready));
        check("req_mem_v", 32'(mem_v_o), 32'(exp_ready));
        if (push && exp_ready && !w) q.push_back('{exp_d, cyc + 2, exact});
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep_checks(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_mem_v"}, 32'(mem_v_o), 32'd1);
            check({tag, "_mem_w"}, 32'(mem_w_o), 32'd1);
            check({tag, "_addr"}, 32'(mem_addr_o), 32'(i));
            check({tag, "_wdata"}, 32'(mem_data_o), 32'd0);
            check({tag, "_ready"}, 32'(ready_o), 32'd0);
            check({tag, "_v_o"}, 32'(v_o), 32'd0);
            if (i == 0) begin
                check({tag, "_init_done_lo"}, 32'(init_done_o), 32'd0);
                check({tag, "_nc_ready"}, 32'(nc_ready_o), 32'd1);
                check({tag, "_nc_init_done"}, 32'(nc_init_done_o), 32'd1);
                check({tag, "_nc_mem_v"}, 32'(nc_mem_v_o), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_done_ready"}, 32'(ready_o), 32'd1);
        check({tag, "_done_init"}, 32'(init_done_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        w_i     = 1'b0;
        addr_i  = 3'd0;
        data_i  = 8'd0;
        yumi_en = 1'b0;

        @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_mem_v", 32'(mem_v_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_nc_ready", 32'(nc_ready_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        sweep_checks("sweep");

        // Write/read ordering with a consumer that takes every response.
        yumi_en = 1'b1;
        req(1'b1, 3'd3, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        req(1'b1, 3'd4, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
        req(1'b0, 3'd4, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1);
        req(1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1);
        idle(4);

        // Backpressure: two reads fill the credits, then stall.
        yumi_en = 1'b0;
        req(1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);
        req(1'b0, 3'd4, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0);
        req(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        req(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        req(1'b1, 3'd5, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
        // Full buffer, dequeue and new read in the same cycle.
        yumi_en = 1'b1;
        req(1'b0, 3'd4, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0);
        yumi_en = 1'b0;
        req(1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        yumi_en = 1'b1;
        idle(4);

        // Reset one cycle after an accepted read: that read must vanish.
        req(1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_v_o", 32'(v_o), 32'd0);
        check("midrst_mem_v", 32'(mem_v_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        sweep_checks("resweep");

        // Memory was cleared by the second sweep.
        req(1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        idle(3);

        begin
            int waited = 0;
            while (q.size() != 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            check("drain_pending", 32'(q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
